// File: rtl/pipe_hazard_fwd_unit_if.sv
// Decode-stage hazard/forwarding bus: ID instruction fields in, operand
// forward selects, PC/IR load enable, issue strobe and stall count out.
interface pipe_hazard_fwd_unit_if #(
  parameter int RADDR_W = 5,
  parameter int FWD_W   = 2,
  parameter int CNT_W   = 16
);
  logic               id_valid;
  logic [RADDR_W-1:0] id_rs;
  logic [RADDR_W-1:0] id_rt;
  logic               id_use_rs;
  logic               id_use_rt;
  logic               id_wreg;
  logic [RADDR_W-1:0] id_rn;
  logic               id_m2reg;
  logic               id_flush;
  logic               mem_busy;
  logic [FWD_W-1:0]   fwda;
  logic [FWD_W-1:0]   fwdb;
  logic               wpcir;
  logic               id_issue;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rn,
           id_m2reg, id_flush, mem_busy,
    input  fwda, fwdb, wpcir, id_issue, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rn,
           id_m2reg, id_flush, mem_busy,
    output fwda, fwdb, wpcir, id_issue, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_fwd_unit.sv
// Hazard/forwarding unit with a private scoreboard of in-flight destination
// registers; resolves operand forwarding, load-use stalls, freeze and flush.
module pipe_hazard_fwd_unit #(
  parameter int RADDR_W    = 5,
  parameter int NSTAGE     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  pipe_hazard_fwd_unit_if.slave bus
);

  typedef struct packed {
    logic             hazard;
    logic [FWD_W-1:0] fwd;
  } lookup_t;

  logic [NSTAGE:1]              v_r;
  logic [NSTAGE:1]              w_r;
  logic [NSTAGE:1]              ld_r;
  logic [NSTAGE:1][RADDR_W-1:0] rn_r;
  logic [CNT_W-1:0]             cnt_r;

  lookup_t la_s;
  lookup_t lb_s;
  logic    stall_s;
  logic    issue_s;
  logic    count_s;

  // Scan from the oldest stage down so the nearest (lowest) stage overwrites.
  function automatic lookup_t lookup(
    input logic [RADDR_W-1:0]             x,
    input logic [NSTAGE:1]                v,
    input logic [NSTAGE:1]                w,
    input logic [NSTAGE:1]                ld,
    input logic [NSTAGE:1][RADDR_W-1:0]   rn
  );
    lookup_t r;
    r = '0;
    for (int s = NSTAGE; s >= 1; s--) begin
      if (v[s] && w[s] && (rn[s] == x) && (x != {RADDR_W{1'b0}})) begin
        r.hazard = ld[s] && (s < LOAD_STAGE);
        r.fwd    = r.hazard ? {FWD_W{1'b0}} : FWD_W'(s);
      end
    end
    return r;
  endfunction

  // Operand lookup, stall and issue decisions for the current ID instruction.
  always_comb begin
    la_s    = lookup(bus.id_rs, v_r, w_r, ld_r, rn_r);
    lb_s    = lookup(bus.id_rt, v_r, w_r, ld_r, rn_r);
    stall_s = bus.id_valid & ((bus.id_use_rs & la_s.hazard) |
                              (bus.id_use_rt & lb_s.hazard));
    issue_s = bus.id_valid & ~stall_s & ~bus.id_flush & ~bus.mem_busy;
    count_s = stall_s & ~bus.id_flush & ~bus.mem_busy;
  end

  assign bus.fwda      = la_s.fwd;
  assign bus.fwdb      = lb_s.fwd;
  assign bus.wpcir     = ~bus.mem_busy & ~(stall_s & ~bus.id_flush);
  assign bus.id_issue  = issue_s;
  assign bus.stall_cnt = cnt_r;

  // Scoreboard shift and saturating stall counter; mem_busy freezes everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_r   <= '0;
      w_r   <= '0;
      ld_r  <= '0;
      rn_r  <= '0;
      cnt_r <= '0;
    end else if (bus.mem_busy) begin
      v_r   <= v_r;
      w_r   <= w_r;
      ld_r  <= ld_r;
      rn_r  <= rn_r;
      cnt_r <= cnt_r;
    end else begin
      for (int s = NSTAGE; s >= 2; s--) begin
        v_r[s]  <= v_r[s-1];
        w_r[s]  <= w_r[s-1];
        ld_r[s] <= ld_r[s-1];
        rn_r[s] <= rn_r[s-1];
      end
      v_r[1]  <= issue_s;
      w_r[1]  <= issue_s & bus.id_wreg;
      ld_r[1] <= issue_s & bus.id_m2reg;
      rn_r[1] <= issue_s ? bus.id_rn : {RADDR_W{1'b0}};
      if (count_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Self-checking bench: directed vector table, hand sequences for freeze,
// reset and counter saturation, and random stimulus against a queue model.
module tb_pipe_hazard_fwd_unit;
  localparam int RADDR_W    = 5;
  localparam int NSTAGE     = 3;
  localparam int LOAD_STAGE = 2;
  localparam int CNT_W      = 16;
  localparam int FWD_W      = 2;
  localparam int CNT2_W     = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int CNT2_MAX   = (1 << CNT2_W) - 1;

  logic clock = 1'b0;
  logic reset;

  pipe_hazard_fwd_unit_if #(.RADDR_W(RADDR_W), .FWD_W(FWD_W), .CNT_W(CNT_W))  bus  ();
  pipe_hazard_fwd_unit_if #(.RADDR_W(RADDR_W), .FWD_W(FWD_W), .CNT_W(CNT2_W)) bus2 ();

  pipe_hazard_fwd_unit #(.RADDR_W(RADDR_W), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE),
                         .CNT_W(CNT_W), .FWD_W(FWD_W))
    dut (.clock(clock), .reset(reset), .bus(bus));

  pipe_hazard_fwd_unit #(.RADDR_W(RADDR_W), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE),
                         .CNT_W(CNT2_W), .FWD_W(FWD_W))
    dut2 (.clock(clock), .reset(reset), .bus(bus2));

  assign bus2.id_valid  = bus.id_valid;
  assign bus2.id_rs     = bus.id_rs;
  assign bus2.id_rt     = bus.id_rt;
  assign bus2.id_use_rs = bus.id_use_rs;
  assign bus2.id_use_rt = bus.id_use_rt;
  assign bus2.id_wreg   = bus.id_wreg;
  assign bus2.id_rn     = bus.id_rn;
  assign bus2.id_m2reg  = bus.id_m2reg;
  assign bus2.id_flush  = bus.id_flush;
  assign bus2.mem_busy  = bus.mem_busy;

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  // Reference model: queue of in-flight writers, element 0 is the EXE stage.
  typedef struct { bit v; bit w; bit ld; int rn; } ent_t;
  ent_t sbm[$];
  int   mcnt;
  int   mcnt2;

  typedef struct {
    int valid, rs, use_rs, rt, use_rt, wreg, rn, m2reg, flush, busy;
    int efa, efb, ewp, eiss, ecnt;
  } vec_t;
  vec_t tab[15];

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    ent_t e;
    e = '{v: 1'b0, w: 1'b0, ld: 1'b0, rn: 0};
    sbm.delete();
    for (int k = 0; k < NSTAGE; k++) sbm.push_back(e);
    mcnt  = 0;
    mcnt2 = 0;
  endfunction

  function automatic void model_src(input int x, output int fwd, output bit haz);
    fwd = 0;
    haz = 1'b0;
    if (x == 0) return;
    for (int k = 0; k < sbm.size(); k++) begin
      if (sbm[k].v && sbm[k].w && sbm[k].rn == x) begin
        if (sbm[k].ld && (k + 1) < LOAD_STAGE) haz = 1'b1;
        else fwd = k + 1;
        return;
      end
    end
  endfunction

  function automatic void model_out(output int fa, output int fb, output int wp,
                                    output int iss, output bit stall);
    bit ha, hb;
    model_src(int'(bus.id_rs), fa, ha);
    model_src(int'(bus.id_rt), fb, hb);
    stall = bus.id_valid && ((bus.id_use_rs && ha) || (bus.id_use_rt && hb));
    wp    = (!bus.mem_busy && !(stall && !bus.id_flush)) ? 1 : 0;
    iss   = (bus.id_valid && !stall && !bus.id_flush && !bus.mem_busy) ? 1 : 0;
  endfunction

  function automatic void model_edge();
    int fa, fb, wp, iss;
    bit stall;
    ent_t e;
    model_out(fa, fb, wp, iss, stall);
    if (!bus.mem_busy) begin
      e = '{v: (iss != 0), w: (iss != 0) && bus.id_wreg,
            ld: (iss != 0) && bus.id_m2reg, rn: (iss != 0) ? int'(bus.id_rn) : 0};
      sbm.push_front(e);
      void'(sbm.pop_back());
      if (stall && !bus.id_flush) begin
        if (mcnt  < CNT_MAX)  mcnt++;
        if (mcnt2 < CNT2_MAX) mcnt2++;
      end
    end
  endfunction

  task automatic drive(input int v, input int rs, input int urs, input int rt, input int urt,
                       input int wreg, input int rn, input int ld, input int fl, input int bz);
    bus.id_valid  = 1'(v);
    bus.id_rs     = RADDR_W'(rs);
    bus.id_use_rs = 1'(urs);
    bus.id_rt     = RADDR_W'(rt);
    bus.id_use_rt = 1'(urt);
    bus.id_wreg   = 1'(wreg);
    bus.id_rn     = RADDR_W'(rn);
    bus.id_m2reg  = 1'(ld);
    bus.id_flush  = 1'(fl);
    bus.mem_busy  = 1'(bz);
  endtask

  task automatic check_model(input string tag);
    int fa, fb, wp, iss;
    bit stall;
    model_out(fa, fb, wp, iss, stall);
    chk({tag, ".fwda"},      int'(bus.fwda),       fa);
    chk({tag, ".fwdb"},      int'(bus.fwdb),       fb);
    chk({tag, ".wpcir"},     int'(bus.wpcir),      wp);
    chk({tag, ".id_issue"},  int'(bus.id_issue),   iss);
    chk({tag, ".stall_cnt"}, int'(bus.stall_cnt),  mcnt);
    chk({tag, ".cnt2"},      int'(bus2.stall_cnt), mcnt2);
  endtask

  task automatic advance();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic run_cycle(input string tag);
    #4;
    check_model(tag);
    advance();
  endtask

  initial begin
    int base;
    //          v rs urs rt urt wr rn ld fl bz   fa fb wp is cnt
    tab[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};
    tab[1]  = '{1, 1, 0, 2, 0, 1, 3, 0, 0, 0,   0, 0, 1, 1, 0};
    tab[2]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0};
    tab[3]  = '{1, 0, 0, 3, 1, 0, 0, 0, 0, 0,   0, 2, 1, 1, 0};
    tab[4]  = '{1, 3, 1, 0, 0, 1, 4, 1, 0, 0,   3, 0, 1, 1, 0};
    tab[5]  = '{1, 3, 1, 4, 1, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0};
    tab[6]  = '{1, 3, 1, 4, 1, 1, 5, 0, 0, 0,   0, 2, 1, 1, 1};
    tab[7]  = '{1, 5, 1, 0, 0, 1, 5, 0, 0, 0,   1, 0, 1, 1, 1};
    tab[8]  = '{1, 5, 1, 4, 1, 1, 0, 1, 0, 0,   1, 0, 1, 1, 1};
    tab[9]  = '{1, 0, 1, 0, 1, 1, 6, 1, 0, 0,   0, 0, 1, 1, 1};
    tab[10] = '{1, 5, 1, 6, 1, 1, 7, 0, 1, 0,   3, 0, 1, 0, 1};
    tab[11] = '{1, 0, 0, 6, 1, 1, 7, 0, 0, 0,   0, 2, 1, 1, 1};
    tab[12] = '{0, 6, 1, 7, 1, 0, 0, 0, 0, 0,   3, 1, 1, 0, 1};
    tab[13] = '{1, 7, 1, 0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 1};
    tab[14] = '{1, 7, 1, 0, 0, 0, 0, 0, 0, 0,   2, 0, 1, 1, 1};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    reset = 1'b0;
    @(posedge clock);
    #1;
    model_reset();

    for (int i = 0; i < 15; i++) begin
      drive(tab[i].valid, tab[i].rs, tab[i].use_rs, tab[i].rt, tab[i].use_rt,
            tab[i].wreg, tab[i].rn, tab[i].m2reg, tab[i].flush, tab[i].busy);
      #4;
      chk($sformatf("tab%0d.fwda", i),      int'(bus.fwda),      tab[i].efa);
      chk($sformatf("tab%0d.fwdb", i),      int'(bus.fwdb),      tab[i].efb);
      chk($sformatf("tab%0d.wpcir", i),     int'(bus.wpcir),     tab[i].ewp);
      chk($sformatf("tab%0d.id_issue", i),  int'(bus.id_issue),  tab[i].eiss);
      chk($sformatf("tab%0d.stall_cnt", i), int'(bus.stall_cnt), tab[i].ecnt);
      advance();
    end

    // Freeze for three cycles in the middle of a load-use stall.
    drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    run_cycle("frz.ld");
    base = mcnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 1);
      #4;
      check_model("frz");
      chk("frz.wpcir", int'(bus.wpcir), 0);
      chk("frz.cnt",   int'(bus.stall_cnt), base);
      advance();
    end
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    #4;
    chk("frz.stall_wpcir", int'(bus.wpcir), 0);
    chk("frz.stall_issue", int'(bus.id_issue), 0);
    advance();
    chk("frz.cnt_inc", int'(bus.stall_cnt), base + 1);
    #4;
    chk("frz.fwdb", int'(bus.fwdb), 2);
    chk("frz.resume_wpcir", int'(bus.wpcir), 1);
    advance();

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0);
      run_cycle("rnd");
    end

    // Reset asserted while a load-use stall is pending.
    drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    run_cycle("rst.ld");
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    #2;
    chk("rst.pre_wpcir", int'(bus.wpcir), 0);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst.fwda",  int'(bus.fwda), 0);
    chk("rst.fwdb",  int'(bus.fwdb), 0);
    chk("rst.wpcir", int'(bus.wpcir), 1);
    chk("rst.cnt",   int'(bus.stall_cnt), 0);
    chk("rst.cnt2",  int'(bus2.stall_cnt), 0);
    #1;
    reset = 1'b0;
    advance();

    // Five load-use stalls: the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
      run_cycle("sat.ld");
      drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
      run_cycle("sat.stall");
      run_cycle("sat.go");
    end
    chk("sat.cnt16", int'(bus.stall_cnt), 5);
    chk("sat.cnt2",  int'(bus2.stall_cnt), 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
